serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder. On `start` it captures two operands and a carry-in, then adds one bit per clock, LSB first, through a single instance of the team's `fulladder` cell (ports `a`, `b`, `cin`, `sum`, `carry`), holding the ripple carry in a flip-flop between cycles. It drives the full-adder stage's inputs and registers its outputs. It gives the lab a small-area alternative to a WIDTH-cell ripple adder.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new addition; sampled only in IDLE.
- `a`  in  WIDTH: operand A; captured on the accepted-start edge.
- `b`  in  WIDTH: operand B; captured on the accepted-start edge.
- `cin`  in  1: carry-in; captured on the accepted-start edge.
- `busy`  out  1: high while in SHIFT.
- `done`  out  1: one-cycle pulse; high while in DONE.
- `sum`  out  WIDTH: result register.
- `cout`  out  1: final carry-out.

## Operation
- State machine states: IDLE, SHIFT, DONE.
- IDLE, start=1: load the A shift register with `a`, the B shift register with `b`, and the carry flop with `cin`. Clear the bit counter to 0. Go to SHIFT.
- IDLE, start=0: stay in IDLE and hold all registers.
- Full-adder inputs are combinational: A_reg[0], B_reg[0], carry flop.
- SHIFT, every edge:
  - A_reg and B_reg shift right by 1, filling with 0.
  - `sum` shifts right by 1, with the full-adder sum inserted at bit WIDTH-1.
  - The carry flop takes the full-adder carry.
  - The counter increments.
- SHIFT, edge where the counter equals WIDTH-1: the shift completes as above. Go to DONE. `cout` takes the full-adder carry on this same edge.
- DONE: go to IDLE on the next edge. A `start` asserted in DONE is ignored.
- `start` is ignored in SHIFT and DONE. There is no queuing. Operands presented during busy have no effect.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Counter width: $clog2(WIDTH) bits. The counter must not wrap before the terminal compare.
- `sum` and `cout` are valid from the DONE cycle onward. They hold until the next accepted start.
- During SHIFT, `sum` holds a partially shifted value and must not be consumed. `cout` keeps its previous result until the final SHIFT edge.

## Timing
- Reset, asynchronous and immediate:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0
  - A_reg, B_reg, carry flop and counter = 0
- Reset mid-operation aborts the addition. No `done` is produced. After `rst` falls, the block waits in IDLE for a new `start`.
- Start accepted at edge k: busy=1 from after edge k through edge k+WIDTH.
- done=1 for exactly the one cycle between edge k+WIDTH and edge k+WIDTH+1. busy=0 in that cycle.
- Latency is WIDTH+1 edges from the accepted start to the DONE cycle.
- Back-to-back operation: the earliest next accepted start is edge k+WIDTH+2, i.e. the first IDLE cycle. Throughput is one addition per WIDTH+2 cycles.
- busy and done are never high at the same time.

## Test plan
- WIDTH=8, a=0x3C, b=0x5A, cin=0, 1-cycle start → done pulses 9 edges later with sum=0x96, cout=0. busy is high for exactly 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, with start issued in the first IDLE cycle after the previous done.
- start held high continuously while different `a`/`b` values are driven during busy → only the first operands are used (0x3C+0x5A=0x96). A second addition of whatever is on `a`/`b` is accepted in the IDLE cycle that follows done.
- Assert rst for 1 cycle at the 4th SHIFT cycle of 0x3C+0x5A → busy=0, done=0, sum=0, cout=0 immediately, with no done afterwards. A new 0x01+0x02 then gives sum=0x03.
- WIDTH=2, exhaustive sweep over all a, b, cin (32 cases) → {cout, sum} = a+b+cin for every case, each completing in 3 edges.
- WIDTH=16, a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, exercising the full carry ripple across all bits.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one fulladder cell, LSB first, WIDTH shift cycles per add.
// Ripple carry is kept in a flop between cycles; {cout, sum} = a + b + cin.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, next;
  logic [WIDTH-1:0]  a_sr, b_sr;
  logic              carry_q;
  logic [CW-1:0]     cnt;
  logic              fa_sum, fa_carry;

  fulladder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = SHIFT;
      SHIFT:   if (cnt == LAST) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr    <= a;
          b_sr    <= b;
          carry_q <= cin;
          cnt     <= '0;
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum     <= {fa_sum, sum[WIDTH-1:1]};
          carry_q <= fa_carry;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) cout <= fa_carry;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed + random checks of serial_adder at WIDTH 2, 8 and 16 against a + b + cin.

module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic        st2, ci2, bz2, dn2, co2;
  logic [1:0]  a2, b2, s2;
  logic        st8, ci8, bz8, dn8, co8;
  logic [7:0]  a8, b8, s8;
  logic        st16, ci16, bz16, dn16, co16;
  logic [15:0] a16, b16, s16;

  serial_adder #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(ci2),
    .busy(bz2), .done(dn2), .sum(s2), .cout(co2));
  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(bz8), .done(dn8), .sum(s8), .cout(co8));
  serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .cin(ci16),
    .busy(bz16), .done(dn16), .sum(s16), .cout(co16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic c);
    case (w)
      2:       begin st2 = s;  a2 = x[1:0];  b2 = y[1:0];  ci2 = c;  end
      8:       begin st8 = s;  a8 = x[7:0];  b8 = y[7:0];  ci8 = c;  end
      default: begin st16 = s; a16 = x;      b16 = y;      ci16 = c; end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    return (w == 2) ? bz2 : (w == 8) ? bz8 : bz16;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 2) ? dn2 : (w == 8) ? dn8 : dn16;
  endfunction

  function automatic logic [31:0] get_res(input int w);
    return (w == 2) ? 32'({co2, s2}) : (w == 8) ? 32'({co8, s8}) : 32'({co16, s16});
  endfunction

  // Reference model: plain integer addition truncated to WIDTH+1 bits.
  function automatic logic [31:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [31:0] m;
    m = (32'd1 << w) - 1;
    return ((32'(x) & m) + (32'(y) & m) + 32'(c)) & ((m << 1) | 32'd1);
  endfunction

  task automatic launch(input int w, input logic [15:0] x, input logic [15:0] y, input logic c);
    drive(w, 1'b1, x, y, c);
    step();
    drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // Called in the cycle right after the accepting edge; returns in the first IDLE cycle.
  task automatic finish(input int w, input logic [31:0] exp, input string tag);
    int nb = 0;
    int guard = 0;
    while (!get_done(w) && guard < w + 6) begin
      if (get_busy(w)) nb++;
      step();
      guard++;
    end
    chk({tag, "_timeout"}, 32'(get_done(w)), 32'd1);
    chk({tag, "_busycycles"}, nb, w);
    chk({tag, "_busy_in_done"}, 32'(get_busy(w)), 32'd0);
    chk({tag, "_result"}, get_res(w), exp);
    step();
    chk({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
    chk({tag, "_hold"}, get_res(w), exp);
  endtask

  initial begin
    logic [15:0] x, y, x2, y2;
    logic        c, c2, saw;
    drive(2, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0);
    drive(16, 0, 0, 0, 0);
    #1;
    chk("rst_busy8", 32'(bz8), 0);
    chk("rst_done8", 32'(dn8), 0);
    chk("rst_res8", get_res(8), 0);
    chk("rst_res16", get_res(16), 0);
    step();
    rst = 1'b0;
    step();
    chk("idle_busy8", 32'(bz8), 0);

    launch(8, 16'h3C, 16'h5A, 1'b0);
    finish(8, 32'h096, "basic8");
    launch(8, 16'hFF, 16'h01, 1'b0);
    finish(8, 32'h100, "ovf8");
    launch(8, 16'hFF, 16'hFF, 1'b1);   // first IDLE cycle after previous done
    finish(8, model(8, 16'hFF, 16'hFF, 1'b1), "b2b8");
    chk("b2b8_const", get_res(8), 32'h1FF);

    // start held high, operands changing during busy
    drive(8, 1'b1, 16'h3C, 16'h5A, 1'b0);
    step();
    saw = 1'b0;
    for (int i = 0; i < 14 && !dn8; i++) begin
      drive(8, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      step();
    end
    x2 = 16'($urandom_range(0, 255));
    y2 = 16'($urandom_range(0, 255));
    c2 = 1'($urandom);
    chk("hold_done", 32'(dn8), 1);
    chk("hold_res", get_res(8), 32'h096);
    drive(8, 1'b1, x2, y2, c2);
    step();
    chk("hold_idle", 32'(bz8 | dn8), 0);
    step();
    drive(8, 1'b0, 0, 0, 0);
    finish(8, model(8, x2, y2, c2), "hold2");

    // reset in the 4th SHIFT cycle
    launch(8, 16'h3C, 16'h5A, 1'b0);
    step(); step(); step();
    chk("mid_busy", 32'(bz8), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bz8), 0);
    chk("abort_done", 32'(dn8), 0);
    chk("abort_res", get_res(8), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (dn8 || bz8) saw = 1'b1;
      step();
    end
    chk("abort_nodone", 32'(saw), 0);
    launch(8, 16'h01, 16'h02, 1'b0);
    finish(8, 32'h003, "after_rst");

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 2; k++) begin
          launch(2, 16'(i), 16'(j), 1'(k));
          finish(2, model(2, 16'(i), 16'(j), 1'(k)), $sformatf("w2_%0d_%0d_%0d", i, j, k));
        end

    launch(16, 16'hFFFF, 16'h0000, 1'b1);
    finish(16, 32'h10000, "ripple16");

    for (int n = 0; n < 10; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom);
      launch(8, x, y, c);
      finish(8, model(8, x, y, c), $sformatf("rnd8_%0d", n));
      launch(16, x, y, c);
      finish(16, model(16, x, y, c), $sformatf("rnd16_%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
